cnn_layer_accel_result_packer: RTL and testbench
================================================

CNN_LAYER_ACCEL_RESULT_PACKER -- requirements
Module: cnn_layer_accel_result_packer

Interface
REQ-001 SHALL have parameter C_NUM_LANES, default 8, meaning 16-bit results packed per output word (fixed 8 for 128-bit output).
REQ-002 SHALL have port clk_if  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port result_valid  input  1  quad result present.
REQ-005 SHALL have port result_accept  output  1  packer takes result this cycle.
REQ-006 SHALL have port result_data  input  16  quad convolution result.
REQ-007 SHALL have port flush  input  1  one-cycle pulse at job completion; emit any partial word.
REQ-008 SHALL have port packed_valid  output  1  packed word present.
REQ-009 SHALL have port packed_ready  input  1  downstream takes word.
REQ-010 SHALL have port packed_data  output  128  lane k in bits [16k+15:16k].
REQ-011 SHALL have port packed_count  output  4  valid lanes in packed_data (1..8).
REQ-012 SHALL have port packed_last  output  1  word is final of job.
REQ-013 SHALL have port flush_done  output  1  one-cycle pulse, job output fully drained.
REQ-014 SHALL have port word_count  output  16  packed words handed off since last flush_done.

Function
REQ-015 SHALL contain an accumulator (acc_data 128b, acc_cnt 0..8) and one output holding register (out_data, out_cnt, out_last, out_valid); packed_* driven directly from the holding register.
REQ-016 SHALL implement FSM states ACCUM, FLUSH, DONE.
REQ-017 SHALL drive result_accept = (state==ACCUM) && (acc_cnt<8), combinationally from registers only.
REQ-018 SHALL, on result_valid&&result_accept, write result_data into lane acc_cnt and increment acc_cnt; first accepted result lands in lane 0.
REQ-019 SHALL treat the holding register as free when !out_valid || packed_ready.
REQ-020 SHALL, when accepting the 8th result (acc_cnt==7) with holding register free, load the completed word directly into the holding register (count 8, last 0) and clear acc_cnt to 0 on the same edge; sustained throughput one result per cycle.
REQ-021 SHALL, when accepting the 8th result with holding register not free, set acc_cnt=8 and deassert result_accept until the word moves to the holding register at the first edge it is free.
REQ-022 SHALL hold packed_data/count/last stable while packed_valid && !packed_ready; clear out_valid on packed_valid&&packed_ready unless reloaded same edge.
REQ-023 SHALL zero unused lanes of a partial word.
REQ-024 SHALL, on flush in ACCUM, go to FLUSH; a result accepted on the same edge as flush is included in the flushed data.
REQ-025 SHALL, in FLUSH: if acc_cnt==8, first move full word (last 0) as in REQ-021; then if 0<acc_cnt<8 and holding register free, load partial word (count=acc_cnt, last=1), clear acc_cnt, go DONE; if acc_cnt==0, go DONE with no word emitted.
REQ-026 SHALL, in DONE, wait until out_valid==0 (or drains this edge), then pulse flush_done for one cycle, clear word_count, return to ACCUM.
REQ-027 SHALL ignore flush outside ACCUM.
REQ-028 SHALL increment word_count on each packed_valid&&packed_ready, saturating at 16'hFFFF.

Reset
REQ-029 SHALL, on rst low, immediately force: state ACCUM, acc_cnt 0, acc_data 0, out_valid 0, packed_data 0, packed_count 0, packed_last 0, flush_done 0, word_count 0; result_accept reads 1 after reset.
REQ-030 SHALL discard any partial or pending word on reset mid-job; no word emitted after release until new results arrive.

Structure
REQ-031 SHALL place FSM state enum and lane-width/lane-count constants in the shared accelerator package with existing accelerator defines.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 Bench SHALL drive 16 results 0x0001..0x0010 back-to-back, packed_ready=1 -> two words, first 0x0008_0007_..._0001, count 8, last 0; result_accept never low.
REQ-034 Bench SHALL hold packed_ready=0 and send 17 results -> first word held stable, result_accept low after 16th accepted, released one cycle after packed_ready=1.
REQ-035 Bench SHALL send 3 results 0xA,0xB,0xC then flush -> one word lanes0-2=A,B,C, lanes3-7=0, count 3, last 1, then flush_done pulse, word_count 0 after.
REQ-036 Bench SHALL flush with acc empty after 8 results -> only full word (last 0), flush_done after its handshake.
REQ-037 Bench SHALL assert rst low with 5 results buffered and packed_valid high -> all outputs reset same cycle, no word appears after release.
REQ-038 Bench SHALL connect packer to quad result port under 20x20, 3x3, stride 1, 2 kernels job with random packed_ready -> unpacked stream matches golden convolution model in order.

Source files
------------

// File: rtl/cnn_layer_accel_result_packer_pkg.sv
// Shared accelerator package for the result path.
// Holds the lane geometry of the packed output word and the packer FSM
// state encoding used by cnn_layer_accel_result_packer.
package cnn_layer_accel_result_packer_pkg;

    // One convolution result occupies one 16-bit lane of the output word.
    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 8;
    localparam int WORD_W    = LANE_W * NUM_LANES;
    // Lane occupancy counters span 0..NUM_LANES inclusive.
    localparam int CNT_W     = 4;
    localparam int WCNT_W    = 16;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } packer_state_e;

endpackage

// File: rtl/cnn_layer_accel_result_packer.sv
// cnn_layer_accel_result_packer
// Packs a stream of 16-bit convolution results into 128-bit words
// (8 lanes, lane k in bits [16k+15:16k]) for the output write path.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ACCUM | accept results into the accumulator, hand off full words
//   ST_FLUSH | job ended: push out a pending full word, then the partial
//   ST_DONE  | wait for the holding register to drain, pulse flush_done
//
// Ports
//   clk_if        in   clock for all logic
//   rst           in   asynchronous, active-low reset
//   result_valid  in   result present on result_data
//   result_accept out  packer takes the result this cycle
//   result_data   in   16-bit result
//   flush         in   one-cycle end-of-job pulse
//   packed_valid  out  packed word present
//   packed_ready  in   downstream takes the word
//   packed_data   out  packed word, unused lanes zero
//   packed_count  out  number of valid lanes (1..8)
//   packed_last   out  final word of the job
//   flush_done    out  one-cycle pulse once the job output has drained
//   word_count    out  words handed off since the last flush_done (saturating)
module cnn_layer_accel_result_packer
    import cnn_layer_accel_result_packer_pkg::*;
#(
    parameter int C_NUM_LANES = NUM_LANES
) (
    input  logic                          clk_if,
    input  logic                          rst,
    input  logic                          result_valid,
    output logic                          result_accept,
    input  logic [LANE_W-1:0]             result_data,
    input  logic                          flush,
    output logic                          packed_valid,
    input  logic                          packed_ready,
    output logic [C_NUM_LANES*LANE_W-1:0] packed_data,
    output logic [CNT_W-1:0]              packed_count,
    output logic                          packed_last,
    output logic                          flush_done,
    output logic [WCNT_W-1:0]             word_count
);

    localparam int              DW       = C_NUM_LANES * LANE_W;
    localparam int              IDX_W    = $clog2(C_NUM_LANES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(C_NUM_LANES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_NUM_LANES - 1);

    packer_state_e      state_q, state_d;
    logic [DW-1:0]      acc_data_q, acc_data_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               flush_done_q, flush_done_d;
    logic [WCNT_W-1:0]  word_count_q, word_count_d;

    logic               hold_free;
    logic               drain;
    logic               take;
    logic               acc_full;
    logic [IDX_W-1:0]   lane_idx;
    logic [DW-1:0]      acc_wr;

    // Accept depends only on registered state so the upstream never sees
    // a combinational path from packed_ready.
    assign result_accept = (state_q == ST_ACCUM) && (acc_cnt_q < FULL_CNT);

    assign hold_free = !out_valid_q || packed_ready;
    assign drain     = out_valid_q && packed_ready;
    assign take      = result_valid && result_accept;
    assign acc_full  = (acc_cnt_q == FULL_CNT);
    assign lane_idx  = acc_cnt_q[IDX_W-1:0];

    always_comb begin
        state_d      = state_q;
        acc_data_d   = acc_data_q;
        acc_cnt_d    = acc_cnt_q;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        flush_done_d = 1'b0;
        word_count_d = word_count_q;

        // Accumulator contents with the incoming result dropped into the
        // next free lane; only used when a result is actually taken.
        acc_wr = acc_data_q;
        acc_wr[lane_idx*LANE_W +: LANE_W] = result_data;

        // A load below overrides this clear when the register refills on
        // the same edge it drains.
        if (drain) begin
            out_valid_d = 1'b0;
            if (word_count_q != '1) begin
                word_count_d = word_count_q + 1'b1;
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (acc_full && hold_free) begin
                    out_data_d  = acc_data_q;
                    out_cnt_d   = FULL_CNT;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_cnt_d   = '0;
                end else if (take) begin
                    if ((acc_cnt_q == LAST_IDX) && hold_free) begin
                        // Bypass straight to the holding register so a
                        // full-rate stream never stalls on word boundaries.
                        out_data_d  = acc_wr;
                        out_cnt_d   = FULL_CNT;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        acc_data_d  = '0;
                        acc_cnt_d   = '0;
                    end else begin
                        acc_data_d = acc_wr;
                        acc_cnt_d  = acc_cnt_q + 1'b1;
                    end
                end
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (acc_full) begin
                    if (hold_free) begin
                        out_data_d  = acc_data_q;
                        out_cnt_d   = FULL_CNT;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        acc_data_d  = '0;
                        acc_cnt_d   = '0;
                    end
                end else if (acc_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if (hold_free) begin
                    // Unused lanes are already zero: the accumulator is
                    // cleared every time a word leaves it.
                    out_data_d  = acc_data_q;
                    out_cnt_d   = acc_cnt_q;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_cnt_d   = '0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                if (hold_free) begin
                    flush_done_d = 1'b1;
                    word_count_d = '0;
                    state_d      = ST_ACCUM;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ACCUM;
            acc_data_q   <= '0;
            acc_cnt_q    <= '0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_data_q   <= acc_data_d;
            acc_cnt_q    <= acc_cnt_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
            word_count_q <= word_count_d;
        end
    end

    assign packed_valid = out_valid_q;
    assign packed_data  = out_data_q;
    assign packed_count = out_cnt_q;
    assign packed_last  = out_last_q;
    assign flush_done   = flush_done_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed bench for cnn_layer_accel_result_packer: full-rate packing,
// backpressure, partial and empty flushes, mid-job reset and a small
// convolution job checked against a golden model.
module tb_cnn_layer_accel_result_packer;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         flush;
    logic         packed_valid;
    logic         packed_ready;
    logic [127:0] packed_data;
    logic [3:0]   packed_count;
    logic         packed_last;
    logic         flush_done;
    logic [15:0]  word_count;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_result_packer #(.C_NUM_LANES(8)) u_dut (
        .clk_if        (clk_if),
        .rst           (rst),
        .result_valid  (result_valid),
        .result_accept (result_accept),
        .result_data   (result_data),
        .flush         (flush),
        .packed_valid  (packed_valid),
        .packed_ready  (packed_ready),
        .packed_data   (packed_data),
        .packed_count  (packed_count),
        .packed_last   (packed_last),
        .flush_done    (flush_done),
        .word_count    (word_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int cyc      = 0;

    logic [127:0] q_data[$];
    logic [3:0]   q_cnt[$];
    logic         q_last[$];
    logic [15:0]  q_stream[$];
    logic [15:0]  gold[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: values read at the edge are the pre-edge values.
    always @(posedge clk_if) begin
        cyc++;
        if (rst && result_valid && result_accept) n_acc++;
        if (rst && packed_valid && packed_ready) begin
            q_data.push_back(packed_data);
            q_cnt.push_back(packed_count);
            q_last.push_back(packed_last);
            for (int i = 0; i < int'(packed_count); i++) begin
                q_stream.push_back(packed_data[i*16 +: 16]);
            end
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_cnt.delete();
        q_last.delete();
        q_stream.delete();
        n_acc = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;
        flush        = 1'b0;
        packed_ready = 1'b0;
        repeat (2) @(posedge clk_if);
        #1 rst = 1'b1;
        @(posedge clk_if);
        #1 clear_q();
    endtask

    task automatic send_one(input logic [15:0] d);
        logic a;
        logic ok;
        ok           = 1'b0;
        result_valid = 1'b1;
        result_data  = d;
        for (int i = 0; i < 200; i++) begin
            a = result_accept;
            @(posedge clk_if);
            #1;
            if (a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", ok, 1'b1);
    endtask

    task automatic send_seq(input int first, input int n);
        for (int i = 0; i < n; i++) send_one(16'(first + i));
        result_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk_if);
        #1 flush = 1'b0;
    endtask

    task automatic wait_flush_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_if);
            #1;
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("flush_done_seen", got, 1'b1);
    endtask

    function automatic int pix(input int r, input int c);
        return (r * 5 + c * 3 + 1) % 32;
    endfunction

    function automatic int wt(input int k, input int i, input int j);
        return (k + i * 2 + j) % 5 + 1;
    endfunction

    initial begin
        int t0;
        logic got;
        logic done;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_accept", result_accept, 1'b1);
        chk("rst_valid", packed_valid, 1'b0);
        chk("rst_data", packed_data, 128'h0);
        chk("rst_count", packed_count, 4'd0);
        chk("rst_last", packed_last, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_word_count", word_count, 16'd0);

        // ---------------- full rate, 16 results ----------------
        packed_ready = 1'b1;
        t0 = cyc;
        send_seq(1, 16);
        chk("b2b_cycles", cyc - t0, 16);
        repeat (3) @(posedge clk_if);
        #1;
        chk("b2b_words", q_data.size(), 2);
        if (q_data.size() == 2) begin
            chk("b2b_w0", q_data[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
            chk("b2b_w0_cnt", q_cnt[0], 4'd8);
            chk("b2b_w0_last", q_last[0], 1'b0);
            chk("b2b_w1", q_data[1], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        end
        chk("b2b_word_count", word_count, 16'd2);

        // ---------------- backpressure, 17 results ----------------
        do_reset();
        fork
            begin
                send_seq(1, 17);
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk_if);
                    #1;
                    if (n_acc == 16) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("bp_reach16", got, 1'b1);
                chk("bp_accept_low", result_accept, 1'b0);
                chk("bp_hold_data", packed_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk_if);
                    #1;
                    chk("bp_stable_data", packed_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
                    chk("bp_stable_valid", packed_valid, 1'b1);
                    chk("bp_still_low", result_accept, 1'b0);
                end
                chk("bp_acc_frozen", n_acc, 16);
                packed_ready = 1'b1;
                @(posedge clk_if);
                #1;
                chk("bp_released", result_accept, 1'b1);
                chk("bp_w1_loaded", packed_data, 128'h0010_000F_000E_000D_000C_000B_000A_0009);
            end
        join
        pulse_flush();
        wait_flush_done();
        chk("bp_words", q_data.size(), 3);
        if (q_data.size() == 3) begin
            chk("bp_w2", q_data[2], 128'h11);
            chk("bp_w2_cnt", q_cnt[2], 4'd1);
            chk("bp_w2_last", q_last[2], 1'b1);
        end

        // ---------------- partial flush ----------------
        do_reset();
        packed_ready = 1'b1;
        send_one(16'h000A);
        send_one(16'h000B);
        send_one(16'h000C);
        result_valid = 1'b0;
        pulse_flush();
        wait_flush_done();
        chk("pf_word_count", word_count, 16'd0);
        chk("pf_words", q_data.size(), 1);
        if (q_data.size() == 1) begin
            chk("pf_data", q_data[0], 128'h0000_0000_0000_0000_0000_000C_000B_000A);
            chk("pf_cnt", q_cnt[0], 4'd3);
            chk("pf_last", q_last[0], 1'b1);
        end
        @(posedge clk_if);
        #1;
        chk("pf_pulse_width", flush_done, 1'b0);
        chk("pf_back_accum", result_accept, 1'b1);

        // ---------------- flush with empty accumulator ----------------
        do_reset();
        send_seq(1, 8);
        pulse_flush();
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_if);
            #1;
            if (flush_done) got = 1'b1;
        end
        chk("ef_no_early_done", got, 1'b0);
        chk("ef_held", packed_valid, 1'b1);
        chk("ef_last", packed_last, 1'b0);
        packed_ready = 1'b1;
        @(posedge clk_if);
        #1;
        chk("ef_done_after_hs", flush_done, 1'b1);
        chk("ef_words", q_data.size(), 1);
        if (q_data.size() == 1) begin
            chk("ef_cnt", q_cnt[0], 4'd8);
            chk("ef_w_last", q_last[0], 1'b0);
        end

        // ---------------- reset mid-job ----------------
        do_reset();
        send_seq(1, 13);
        chk("mr_pending", packed_valid, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("mr_valid", packed_valid, 1'b0);
        chk("mr_data", packed_data, 128'h0);
        chk("mr_count", packed_count, 4'd0);
        chk("mr_last", packed_last, 1'b0);
        chk("mr_word_count", word_count, 16'd0);
        chk("mr_accept", result_accept, 1'b1);
        @(posedge clk_if);
        @(posedge clk_if);
        #1 rst = 1'b1;
        packed_ready = 1'b1;
        clear_q();
        repeat (20) @(posedge clk_if);
        #1;
        chk("mr_no_words", q_data.size(), 0);
        chk("mr_idle", packed_valid, 1'b0);

        // ---------------- convolution job ----------------
        do_reset();
        gold.delete();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 18; r++)
                for (int c = 0; c < 18; c++) begin
                    int s;
                    s = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s += pix(r + i, c + j) * wt(k, i, j);
                    gold.push_back(16'(s));
                end
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < gold.size(); n++) send_one(gold[n]);
                result_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_if);
                    #1 packed_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        packed_ready = 1'b1;
        pulse_flush();
        wait_flush_done();
        chk("cv_len", q_stream.size(), gold.size());
        if (q_stream.size() == gold.size()) begin
            for (int n = 0; n < gold.size(); n++) chk("cv_elem", q_stream[n], gold[n]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
